fp_cvt_sched: RTL and testbench

Round-robin scheduler that shares one single-to-triple (FP32 to FP96) widening converter among NREQ requesters. Each request is accepted with a valid/ready handshake, converted through a two-stage pipeline, and returned on a single result port with requester ID and tag. The block sits between the issue queues of several functional units and the shared precision-conversion resource, with full backpressure on both sides.

---
 rtl/fp_cvt_sched_pkg.sv | 40 ++++
 rtl/fp_cvt_s2t_core.sv | 51 +++++
 rtl/fp_cvt_sched.sv | 150 +++++++++++++++
 tb/tb_fp_cvt_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cvt_sched_pkg.sv
// fp_cvt_sched_pkg
// Shared definitions for the FP32 -> FP96 conversion scheduler:
//   - field widths of the FP32 and FP96 formats
//   - exponent biases and the re-bias delta between the two formats
//   - packed struct views of both formats
//   - small helper that left-aligns an FP32 significand into FP96
package fp_cvt_sched_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_SIG_W = 23;
  localparam int FP96_EXP_W = 15;
  localparam int FP96_SIG_W = 80;

  localparam logic [FP32_EXP_W-1:0] FP32_BIAS    = 8'h7F;
  localparam logic [FP96_EXP_W-1:0] FP96_BIAS    = 15'h3FFF;
  // 0x3FFF - 0x7F = 0x3F80; added to a biased FP32 exponent it yields the
  // biased FP96 exponent. The largest finite input (0xFE) stays below 0x7FFF.
  localparam logic [FP96_EXP_W-1:0] FP_BIAS_DELTA = FP96_BIAS - {7'd0, FP32_BIAS};

  localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = '1;
  localparam logic [FP96_EXP_W-1:0] FP96_EXP_MAX = '1;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_SIG_W-1:0] sig;
  } fp32_t;

  typedef struct packed {
    logic                  sign;
    logic [FP96_EXP_W-1:0] exp;
    logic [FP96_SIG_W-1:0] sig;
  } fp96_t;

  // FP32 fraction placed at the top of the FP96 fraction field, zero padded.
  function automatic logic [FP96_SIG_W-1:0] widen_sig(input logic [FP32_SIG_W-1:0] s);
    return {s, {(FP96_SIG_W-FP32_SIG_W){1'b0}}};
  endfunction

endpackage

// File: rtl/fp_cvt_s2t_core.sv
// fp_cvt_s2t_core
// Purely combinational FP32 -> FP96 widening conversion.
//   a_i        FP32 operand
//   y_o        FP96 result {sign, exp[14:0], sig[79:0]}
//   invalid_o  set when a signalling NaN was quieted
// Optional feature macro: FPCVT_SNAN_QUIET_EN
//   defined   : SNaN inputs get sig[79] forced to 1 and invalid_o = 1
//   undefined : NaN payload passed through unmodified, invalid_o = 0
// Zero and FP32 denormals flush to a signed zero.
module fp_cvt_s2t_core
  import fp_cvt_sched_pkg::*;
(
  input  logic [31:0] a_i,
  output logic [95:0] y_o,
  output logic        invalid_o
);

  fp32_t in_s;
  fp96_t res_s;
  logic  inv_s;

  assign in_s = fp32_t'(a_i);

  always_comb begin
    res_s      = '0;
    inv_s      = 1'b0;
    res_s.sign = in_s.sign;
    if (in_s.exp == FP32_EXP_MAX) begin
      // Inf / NaN: saturate the exponent, keep the payload bits.
      res_s.exp = FP96_EXP_MAX;
      res_s.sig = widen_sig(in_s.sig);
`ifdef FPCVT_SNAN_QUIET_EN
      // Signalling NaN: nonzero payload with the quiet bit clear.
      if ((in_s.sig != '0) && !in_s.sig[FP32_SIG_W-1]) begin
        res_s.sig[FP96_SIG_W-1] = 1'b1;
        inv_s                   = 1'b1;
      end
`endif
    end else if (in_s.exp == '0) begin
      res_s.exp = '0;
      res_s.sig = '0;
    end else begin
      res_s.exp = {7'd0, in_s.exp} + FP_BIAS_DELTA;
      res_s.sig = widen_sig(in_s.sig);
    end
  end

  assign y_o       = res_s;
  assign invalid_o = inv_s;

endmodule

// File: rtl/fp_cvt_sched.sv
// fp_cvt_sched
// Round-robin scheduler sharing one FP32 -> FP96 converter among NREQ
// requesters, with a two-stage pipeline (A: capture, B: converted result).
// Parameters: NREQ (2..8), TAGW, IDW = $clog2(NREQ).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid      per-requester request present
//   req_data       per-requester FP32 operand
//   req_tag        per-requester opaque tag
//   req_ready      one-hot grant (or zero)
//   out_valid      result available
//   out_ready      consumer accepts result
//   out_data       FP96 result
//   out_id         requester that issued the result
//   out_tag        tag of that request
//   out_invalid    signalling-NaN flag (FPCVT_SNAN_QUIET_EN)
//   busy           any pipeline stage occupied
// Optional feature macro: FPCVT_SNAN_QUIET_EN (handled in fp_cvt_s2t_core).
//
// Handshake: a transfer happens on a port in any cycle where valid & ready
// are both high at the rising clock edge. Producers hold valid and payload
// stable until the transfer; ready may depend combinationally on valid, but
// valid must never depend on ready. out_* stay stable while
// out_valid & !out_ready.
module fp_cvt_sched
  import fp_cvt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][31:0]     req_data,
  input  logic [NREQ-1:0][TAGW-1:0] req_tag,
  output logic [NREQ-1:0]           req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [95:0]               out_data,
  output logic [IDW-1:0]            out_id,
  output logic [TAGW-1:0]           out_tag,
  output logic                      out_invalid,
  output logic                      busy
);

  // ---------------- state ----------------
  logic [IDW-1:0]  last_gnt_q, last_gnt_d;
  logic            va_q, va_d;
  logic [31:0]     a_data_q;
  logic [TAGW-1:0] a_tag_q;
  logic [IDW-1:0]  a_id_q;
  logic            vb_q, vb_d;
  logic [95:0]     out_data_q;
  logic [IDW-1:0]  out_id_q;
  logic [TAGW-1:0] out_tag_q;
  logic            out_inv_q;

  // ---------------- flow control ----------------
  logic ready_b, ready_a;
  assign ready_b = !vb_q || out_ready;
  assign ready_a = !va_q || ready_b;

  // ---------------- arbitration ----------------
  // Search starts just after the last granted requester, so the most
  // recently served one has lowest priority. Reset points last_gnt at
  // NREQ-1, making requester 0 the first in line.
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] arb_idx;
  logic           xfer;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    arb_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      arb_idx = IDW'((int'(last_gnt_q) + k) % NREQ);
      if (!gnt_found && req_valid[arb_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = arb_idx;
      end
    end
  end

  // No grant is offered while reset is asserted.
  assign xfer = gnt_found && ready_a && !rst;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  // Pointer moves only on a real transfer; idle cycles leave it alone.
  assign last_gnt_d = xfer ? gnt_idx : last_gnt_q;
  assign va_d       = ready_a ? xfer : va_q;
  assign vb_d       = ready_b ? va_q : vb_q;

  // ---------------- conversion ----------------
  logic [95:0] conv_data;
  logic        conv_inv;

  fp_cvt_s2t_core u_core (
    .a_i       (a_data_q),
    .y_o       (conv_data),
    .invalid_o (conv_inv)
  );

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= IDW'(NREQ-1);
      va_q       <= 1'b0;
      a_data_q   <= '0;
      a_tag_q    <= '0;
      a_id_q     <= '0;
      vb_q       <= 1'b0;
      out_data_q <= '0;
      out_id_q   <= '0;
      out_tag_q  <= '0;
      out_inv_q  <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      va_q       <= va_d;
      vb_q       <= vb_d;
      if (xfer) begin
        a_data_q <= req_data[gnt_idx];
        a_tag_q  <= req_tag[gnt_idx];
        a_id_q   <= gnt_idx;
      end
      // Result registers load only when stage B is free to take a new
      // entry, which keeps out_* frozen under backpressure.
      if (ready_b && va_q) begin
        out_data_q <= conv_data;
        out_id_q   <= a_id_q;
        out_tag_q  <= a_tag_q;
        out_inv_q  <= conv_inv;
      end
    end
  end

  // ---------------- outputs ----------------
  assign out_valid   = vb_q;
  assign out_data    = out_data_q;
  assign out_id      = out_id_q;
  assign out_tag     = out_tag_q;
  assign out_invalid = out_inv_q;
  assign busy        = va_q || vb_q;

endmodule

// File: tb/tb_fp_cvt_sched.sv
// tb_fp_cvt_sched
// Directed bench for fp_cvt_sched (NREQ=4, TAGW=4). Inputs change #1 after
// the rising edge; outputs are sampled on the falling edge.
module tb_fp_cvt_sched;

  localparam int NREQ = 4;
  localparam int TAGW = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + TAGW + 96;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][31:0]     req_data;
  logic [NREQ-1:0][TAGW-1:0] req_tag;
  logic [NREQ-1:0]           req_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [95:0]               out_data;
  logic [IDW-1:0]            out_id;
  logic [TAGW-1:0]           out_tag;
  logic                      out_invalid;
  logic                      busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0]  exp_q[$];
  logic [31:0]   rr_dat[NREQ];
  logic [95:0]   rr_exp[NREQ];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  fp_cvt_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_tag     (req_tag),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
    .out_tag     (out_tag),
    .out_invalid (out_invalid),
    .busy        (busy)
  );

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One isolated request; returns the grant seen, out_valid one cycle after
  // the accept, and the output fields two cycles after the accept.
  task automatic send_one(input logic [1:0] id, input logic [31:0] d, input logic [3:0] t,
                          output logic [3:0] rdy, output logic early, output logic ov,
                          output logic [95:0] od, output logic [1:0] oid,
                          output logic [3:0] otag, output logic oinv);
    req_data[id] = d;
    req_tag[id]  = t;
    req_valid    = 4'b0001 << id;
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    early = out_valid;
    @(posedge clk);
    @(negedge clk);
    ov   = out_valid;
    od   = out_data;
    oid  = out_id;
    otag = out_tag;
    oinv = out_invalid;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    req_valid = 4'hF;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_data !== 96'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    tests_run++;
    if (out_id !== 2'd0 || out_tag !== 4'd0 || out_invalid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_fields: got id %0d tag %0d inv %b expected 0 0 0", out_id, out_tag, out_invalid);
    end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] rdy; logic early, ov, oinv; logic [95:0] od; logic [1:0] oid; logic [3:0] otag;
    apply_reset();
    send_one(2'd2, 32'h3F80_0000, 4'd5, rdy, early, ov, od, oid, otag, oinv);
    tests_run++;
    if (rdy !== 4'b0100) begin tests_failed++; $display("FAIL single_grant: got %b expected 0100", rdy); end
    tests_run++;
    if (early !== 1'b0) begin tests_failed++; $display("FAIL single_latency_early: got out_valid %b expected 0", early); end
    tests_run++;
    if (ov !== 1'b1) begin tests_failed++; $display("FAIL single_out_valid: got %b expected 1", ov); end
    tests_run++;
    if (od !== 96'h3FFF_0000_0000_0000_0000_0000) begin
      tests_failed++; $display("FAIL single_data: got %h expected 3fff00000000000000000000", od);
    end
    tests_run++;
    if (oid !== 2'd2 || otag !== 4'd5 || oinv !== 1'b0) begin
      tests_failed++; $display("FAIL single_id_tag: got id %0d tag %0d inv %b expected 2 5 0", oid, otag, oinv);
    end
  endtask

  // Full load on all requesters; out_ready dropped for stall_len cycles.
  // A small occupancy model predicts when a grant must be offered.
  task automatic test_load(input int stall_len, input string name);
    logic m_va, m_vb, exp_rdy, rb, ra;
    int exp_next;
    logic [W-1:0] got, want;
    apply_reset();
    exp_q.delete();
    m_va = 1'b0; m_vb = 1'b0; exp_next = 0;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i] = rr_dat[i];
      req_tag[i]  = 4'(i + 5);
    end
    for (int cyc = 0; cyc < 26; cyc++) begin
      out_ready = (stall_len > 0 && cyc >= 4 && cyc < 4 + stall_len) ? 1'b0 : 1'b1;
      req_valid = (cyc < 16) ? 4'hF : 4'h0;
      @(negedge clk);
      exp_rdy = (cyc < 16) && (!m_va || !m_vb || out_ready);
      tests_run++;
      if (out_valid !== m_vb) begin
        tests_failed++; $display("FAIL %s_out_valid c%0d: got %b expected %b", name, cyc, out_valid, m_vb);
      end
      tests_run++;
      if ((req_ready !== 4'b0000) !== exp_rdy) begin
        tests_failed++; $display("FAIL %s_ready c%0d: got %b expected grant=%b", name, cyc, req_ready, exp_rdy);
      end
      if (exp_rdy) begin
        tests_run++;
        if (req_ready !== (4'b0001 << exp_next)) begin
          tests_failed++; $display("FAIL %s_grant c%0d: got %b expected index %0d", name, cyc, req_ready, exp_next);
        end
        exp_q.push_back({2'(exp_next), 4'(exp_next + 5), rr_exp[exp_next]});
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got = {out_id, out_tag, out_data};
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL %s_extra_result c%0d: got %h expected none", name, cyc, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            tests_failed++; $display("FAIL %s_result c%0d: got %h expected %h", name, cyc, got, want);
          end
        end
      end
      rb = !m_vb || out_ready;
      ra = !m_va || rb;
      if (rb) m_vb = m_va;
      if (ra) m_va = exp_rdy;
      if (exp_rdy) exp_next = (exp_next + 1) % NREQ;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL %s_lost_results: got %0d outstanding expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    test_load(0, "rr");
  endtask

  task automatic test_backpressure();
    test_load(5, "bp");
  endtask

  task automatic test_special();
    logic [3:0] rdy; logic early, ov, oinv; logic [95:0] od; logic [1:0] oid; logic [3:0] otag;
    logic [95:0] snan_exp; logic snan_inv;
`ifdef FPCVT_SNAN_QUIET_EN
    snan_exp = 96'h7FFF_8000_0200_0000_0000_0000;
    snan_inv = 1'b1;
`else
    snan_exp = 96'h7FFF_0000_0200_0000_0000_0000;
    snan_inv = 1'b0;
`endif
    apply_reset();
    send_one(2'd1, 32'h8000_0001, 4'd3, rdy, early, ov, od, oid, otag, oinv);
    tests_run++;
    if (ov !== 1'b1 || od !== 96'h8000_0000_0000_0000_0000_0000) begin
      tests_failed++; $display("FAIL neg_denormal: got v%b %h expected v1 800000000000000000000000", ov, od);
    end
    send_one(2'd3, 32'h7F80_0000, 4'd9, rdy, early, ov, od, oid, otag, oinv);
    tests_run++;
    if (od !== 96'h7FFF_0000_0000_0000_0000_0000 || oinv !== 1'b0) begin
      tests_failed++; $display("FAIL pos_inf: got %h inv %b expected 7fff00000000000000000000 inv 0", od, oinv);
    end
    send_one(2'd0, 32'h7F80_0001, 4'd1, rdy, early, ov, od, oid, otag, oinv);
    tests_run++;
    if (od !== snan_exp) begin tests_failed++; $display("FAIL snan_data: got %h expected %h", od, snan_exp); end
    tests_run++;
    if (oinv !== snan_inv) begin tests_failed++; $display("FAIL snan_invalid: got %b expected %b", oinv, snan_inv); end
    send_one(2'd2, 32'h7FC0_0000, 4'd2, rdy, early, ov, od, oid, otag, oinv);
    tests_run++;
    if (od !== 96'h7FFF_8000_0000_0000_0000_0000 || oinv !== 1'b0) begin
      tests_failed++; $display("FAIL qnan: got %h inv %b expected 7fff80000000000000000000 inv 0", od, oinv);
    end
    send_one(2'd1, 32'hC040_0000, 4'd7, rdy, early, ov, od, oid, otag, oinv);
    tests_run++;
    if (od !== 96'hC000_8000_0000_0000_0000_0000 || oid !== 2'd1 || otag !== 4'd7) begin
      tests_failed++; $display("FAIL neg_three: got %h id %0d tag %0d expected c00080000000000000000000 id 1 tag 7", od, oid, otag);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_data[i] = rr_dat[i];
      req_tag[i]  = 4'(i + 5);
    end
    out_ready = 1'b0;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL mid_full: got busy %b ov %b rdy %b expected 1 1 0000", busy, out_valid, req_ready);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL mid_flushed: got ov %b busy %b expected 0 0", out_valid, busy);
    end
    tests_run++;
    if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_tag   = '0;
    out_ready = 1'b1;
    rr_dat[0] = 32'h3F80_0000; rr_exp[0] = 96'h3FFF_0000_0000_0000_0000_0000; // 1.0
    rr_dat[1] = 32'h4000_0000; rr_exp[1] = 96'h4000_0000_0000_0000_0000_0000; // 2.0
    rr_dat[2] = 32'hC040_0000; rr_exp[2] = 96'hC000_8000_0000_0000_0000_0000; // -3.0
    rr_dat[3] = 32'h3E80_0000; rr_exp[3] = 96'h3FFD_0000_0000_0000_0000_0000; // 0.25

    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_special();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
